// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one product/quotient bit per cycle.
// Fixed latency: IDLE -> CALC (XLEN cycles) -> FIX (1 cycle) -> DONE pulse. New starts are ignored while busy.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int SELECT_LEN = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [SELECT_LEN-1:0] rd_in,
  input  logic [XLEN-1:0]       a_in,
  input  logic [XLEN-1:0]       b_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [SELECT_LEN-1:0] store_sel
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic [CW-1:0]         count;
  logic [2:0]            op;
  logic [SELECT_LEN-1:0] rd;
  logic [XLEN-1:0]       a_raw;
  logic                  b_zero;
  logic                  neg_q;
  logic                  neg_r;
  logic [XLEN-1:0]       hi;
  logic [XLEN-1:0]       lo;
  logic [XLEN-1:0]       mcand;

  // Operand classification and magnitudes at the accept edge
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_sgn = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign a_neg = a_sgn && a_in[XLEN-1];
  assign b_neg = b_sgn && b_in[XLEN-1];
  assign a_mag = a_neg ? -a_in : a_in;
  assign b_mag = b_neg ? -b_in : b_in;

  // Iteration datapaths: hi is the running partial product / partial remainder
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_sh;
  logic [XLEN:0] div_diff;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, mcand};

  // Sign correction and special cases applied in FIX
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val;

  assign prod_s = neg_q ? -{hi, lo} : {hi, lo};
  assign quo_s  = neg_q ? -lo : lo;
  assign rem_s  = neg_r ? -hi : hi;

  always_comb begin
    fix_val = '0;
    if (!op[2]) begin
      fix_val = (op == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (!op[1]) begin
      fix_val = b_zero ? '1 : quo_s;
    end else begin
      fix_val = b_zero ? a_raw : rem_s;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == CW'(XLEN - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done  = 1'b1;
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign store_sel = done ? rd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      op     <= '0;
      rd     <= '0;
      a_raw  <= '0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count  <= '0;
        op     <= funct3;
        rd     <= rd_in;
        a_raw  <= a_in;
        b_zero <= (b_in == '0);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        hi     <= '0;
        // Divide: lo holds the dividend and shifts in quotient bits; multiply: lo holds the multiplier
        lo     <= funct3[2] ? a_mag : b_mag;
        mcand  <= funct3[2] ? b_mag : a_mag;
      end else if (state == CALC) begin
        count <= count + CW'(1);
        if (op[2]) begin
          if (!div_diff[XLEN]) begin
            hi <= div_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= div_sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
        end else begin
          {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
        end
      end
      if (state == FIX) result <= fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle output comparison,
// directed literal cases, handshake/reset scenarios and randomized operations.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  store_sel;

  muldiv_unit #(.XLEN(32), .SELECT_LEN(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rd_in(rd_in),
    .a_in(a_in), .b_in(b_in), .ready(ready), .busy(busy), .done(done),
    .result(result), .store_sel(store_sel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, r;
    logic [63:0] bits;
    bit          as_s, bs_s;
    as_s = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    bs_s = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    sa   = as_s ? longint'($signed(a)) : longint'({32'b0, a});
    sb   = bs_s ? longint'($signed(b)) : longint'({32'b0, b});
    case (f)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        r    = sa * sb;
        bits = r;
        return (f == 3'd0) ? bits[31:0] : bits[63:32];
      end
      3'd4, 3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (f == 3'd4 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r    = sa / sb;
        bits = r;
        return bits[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        if (f == 3'd6 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r    = sa % sb;
        bits = r;
        return bits[31:0];
      end
    endcase
  endfunction

  // Behavioural timing model: an accepted op completes 33 edges after its accept edge
  bit          live = 0;
  bit          m_pend = 0;
  bit          m_done = 0;
  int          m_cnt = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_rd = '0;
  logic [4:0]  m_exp_rd = '0;

  initial forever begin
    @(posedge clk);
    live = 1;
    if (reset) begin
      m_pend   = 0;
      m_done   = 0;
      m_result = '0;
    end else begin
      m_done = 0;
      if (m_pend) begin
        m_cnt++;
        if (m_cnt == 33) begin
          m_pend   = 0;
          m_done   = 1;
          m_result = m_exp;
          m_rd     = m_exp_rd;
        end
      end else if (start) begin
        m_pend   = 1;
        m_cnt    = 0;
        m_exp    = ref_op(funct3, a_in, b_in);
        m_exp_rd = rd_in;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      check("cyc_done",      32'(done),      32'(m_done));
      check("cyc_busy",      32'(busy),      32'(m_pend));
      check("cyc_ready",     32'(ready),     32'(!m_pend));
      check("cyc_store_sel", 32'(store_sel), 32'(m_done ? m_rd : 5'd0));
      check("cyc_result",    result,         m_result);
    end
  end

  // Issue one op and wait for its done; latency counted in edges from the cycle start is raised
  task automatic do_op(input string name, input logic [2:0] f, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit use_lit, input logic [31:0] lit, input bit now, input bit poke);
    int lat;
    bit seen;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    start  = 1'b1;
    funct3 = f;
    rd_in  = rd;
    a_in   = a;
    b_in   = b;
    @(posedge clk);
    lat = 1;
    seen = 0;
    #1;
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    while (lat < 60) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
      if (poke && lat == 5) begin
        #1;
        start  = 1'b1;
        funct3 = 3'($urandom_range(0, 7));
        rd_in  = 5'd31;
        a_in   = $urandom;
        b_in   = $urandom;
      end else if (poke && lat == 6) begin
        #1;
        start = 1'b0;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({name, "_latency"},   32'(lat),       32'd34);
      check({name, "_store_sel"}, 32'(store_sel), 32'(rd));
      check({name, "_vs_model"},  result,         ref_op(f, a, b));
      if (use_lit) begin
        check({name, "_result"},    result,   lit);
        check({name, "_model_pin"}, ref_op(f, a, b), lit);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    rd_in  = '0;
    a_in   = '0;
    b_in   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready",     32'(ready),     32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_store_sel", 32'(store_sel), 32'd0);

    do_op("mul_neg",  3'd0, 5'd5,  32'd7,          32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0, 0);
    @(negedge clk);
    check("mul_neg_store_sel_clear", 32'(store_sel), 32'd0);
    check("mul_neg_done_clear",      32'(done),      32'd0);
    do_op("mulh",     3'd1, 5'd6,  32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 0, 0);
    do_op("mulhu",    3'd3, 5'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0, 0);
    do_op("mulhsu",   3'd2, 5'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0);
    do_op("div_neg",  3'd4, 5'd9,  32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 0, 0);
    do_op("rem_neg",  3'd6, 5'd10, 32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 0, 0);
    do_op("divu",     3'd5, 5'd11, 32'hFFFF_FFFE, 32'd2,         1, 32'h7FFF_FFFF, 0, 0);
    do_op("remu",     3'd7, 5'd12, 32'd10,        32'd3,         1, 32'd1,         0, 0);
    do_op("div_by0",  3'd4, 5'd13, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 0, 0);
    do_op("remu_by0", 3'd7, 5'd14, 32'd5,         32'd0,         1, 32'd5,         0, 0);
    do_op("div_ovf",  3'd4, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0);
    do_op("rem_ovf",  3'd6, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         0, 0);
    do_op("rem_by0n", 3'd6, 5'd17, 32'hFFFF_FFF0, 32'd0,         1, 32'hFFFF_FFF0, 0, 0);

    do_op("poke_calc", 3'd0, 5'd3, 32'd6,  32'd9, 1, 32'd54, 0, 1);
    do_op("b2b_first", 3'd5, 5'd4, 32'd100, 32'd7, 1, 32'd14, 0, 0);
    do_op("b2b_second", 3'd7, 5'd2, 32'd100, 32'd7, 1, 32'd2, 1, 0);
    do_op("rd_zero",   3'd0, 5'd0, 32'd11, 32'd11, 1, 32'd121, 0, 0);

    @(posedge clk);
    #1;
    start  = 1'b1;
    funct3 = 3'd4;
    rd_in  = 5'd20;
    a_in   = 32'd1000;
    b_in   = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_ready",     32'(ready),     32'd1);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_done",      32'(done),      32'd0);
    check("midrst_result",    result,         32'd0);
    check("midrst_store_sel", 32'(store_sel), 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    do_op("after_rst_mul", 3'd0, 5'd21, 32'd3, 32'd4, 1, 32'd12, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       ra = 32'd0;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'd1;
        3:       rb = 32'($urandom_range(2, 1000));
        default: rb = $urandom;
      endcase
      do_op("rand", rf, 5'($urandom_range(0, 31)), ra, rb, 0, 32'd0, 0, 0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
